// File: rtl/sync_dp_ram_init_if.sv
// Port bundle for sync_dp_ram_init.
//   master : driven by the port A/B clients (loader and compute side)
//   slave  : the RAM itself
// Signals:
//   clr_req            request to re-zero the whole array
//   data_a/b, addr_a/b write data and address, ports A/B
//   we_a/b             write enable, ports A/B
//   q_a/b              registered read data, ports A/B
//   ready              array cleared, ports live
//   collision          both ports wrote the same in-range address
//   addr_err           either port presented an out-of-range address
interface sync_dp_ram_init_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  clr_req;
    logic [DATA_WIDTH-1:0] data_a, data_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic                  we_a, we_b;
    logic [DATA_WIDTH-1:0] q_a, q_b;
    logic                  ready;
    logic                  collision;
    logic                  addr_err;

    modport master (
        output clr_req, data_a, data_b, addr_a, addr_b, we_a, we_b,
        input  q_a, q_b, ready, collision, addr_err
    );

    modport slave (
        input  clr_req, data_a, data_b, addr_a, addr_b, we_a, we_b,
        output q_a, q_b, ready, collision, addr_err
    );
endinterface

// File: rtl/sync_dp_ram_init.sv
// True dual-port synchronous RAM for the channel buffers, with a sequential
// clear engine (one word zeroed per cycle), selectable same-port
// read-during-write, port-A-wins collision handling and out-of-range
// address protection.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset; restarts the clear from word 0
//   bus    sync_dp_ram_init_if.slave (port A, port B, clear request, status)
`ifndef In_rows
`define In_rows 4
`endif
`ifndef CHANS_PER_MEM
`define CHANS_PER_MEM 4
`endif
`ifndef RAM_DEPTH_ROWS
`define RAM_DEPTH_ROWS 16
`endif

module sync_dp_ram_init #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = `In_rows * `CHANS_PER_MEM * `RAM_DEPTH_ROWS,
    parameter int RDW_MODE   = 0     // 0 = write-first, 1 = read-first
) (
    input logic               clk,
    input logic               rst_n,
    sync_dp_ram_init_if.slave bus
);
    // One extra bit so a depth of exactly 2**ADDR_WIDTH still compares cleanly.
    localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

    logic                  live;
    logic                  in_a, in_b;
    logic                  wr_a, wr_b;
    logic                  same_addr;
    logic                  coll;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic [DATA_WIDTH-1:0] q_a_r, q_b_r;
    logic                  coll_r, aerr_r;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                // Terminal compare against the last real word, never a wrap.
                if (clr_cnt == LAST) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // ---------------- port decode ----------------
    assign live      = (state == READY);
    assign in_a      = ({1'b0, bus.addr_a} < DEPTH);
    assign in_b      = ({1'b0, bus.addr_b} < DEPTH);
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign wr_a      = live & bus.we_a & in_a;
    // Port A wins a same-address collision, so B's write is suppressed.
    assign coll      = wr_a & bus.we_b & in_b & same_addr;
    assign wr_b      = live & bus.we_b & in_b & ~coll;

    // Reads see the pre-edge array, so a cross-port read of a word being
    // written this cycle always returns the old word.
    always_comb begin
        rd_a = '0;
        if (in_a)
            rd_a = (bus.we_a && RDW_MODE == 0) ? bus.data_a : ram[bus.addr_a];
    end

    always_comb begin
        rd_b = '0;
        if (in_b)
            rd_b = (bus.we_b && RDW_MODE == 0) ? bus.data_b : ram[bus.addr_b];
    end

    // ---------------- array ----------------
    // No reset on the array itself; the clear engine zeroes it word by word.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            ram[clr_cnt] <= '0;
        end else begin
            if (wr_a) ram[bus.addr_a] <= bus.data_a;
            if (wr_b) ram[bus.addr_b] <= bus.data_b;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_r  <= '0;
            q_b_r  <= '0;
            coll_r <= 1'b0;
            aerr_r <= 1'b0;
        end else if (live) begin
            q_a_r  <= rd_a;
            q_b_r  <= rd_b;
            coll_r <= coll;
            aerr_r <= ~(in_a & in_b);
        end else begin
            q_a_r  <= '0;
            q_b_r  <= '0;
            coll_r <= 1'b0;
            aerr_r <= 1'b0;
        end
    end

    assign bus.q_a       = q_a_r;
    assign bus.q_b       = q_b_r;
    assign bus.collision = coll_r;
    assign bus.addr_err  = aerr_r;
    assign bus.ready     = live;
endmodule
